// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer family.
// Contents:
//   WORD_SIZE_DEF / FRAC_BITS_DEF : default Q-format word and fraction widths
//   SAT_W                         : working width handed to sat_round
//   state_t                       : sequencer states (IDLE, ACCUM, WRITE, DONE)
//   sat_round                     : Q-format rescale, saturation and optional ReLU
package fc_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int FRAC_BITS_DEF = 8;
    localparam int SAT_W         = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Callers sign-extend their accumulator to SAT_W bits and keep the low
    // word_size bits of the result. The arithmetic shift floors toward -inf.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac_bits,
        input int                      word_size,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        r     = acc >>> frac_bits;
        max_v = 64'sd1 <<< (word_size - 1);
        max_v = max_v - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One multiply-accumulate lane of the sequential fully-connected layer.
// Ports:
//   clk    in  clock
//   load   in  load acc with the bias scaled into the Q format (bias << FRAC_BITS)
//   acc_en in  add the full-precision product w*x to acc
//   bias   in  signed bias word
//   w, x   in  signed weight and input words
//   acc    out signed accumulator, ACC_WIDTH bits
// With neither load nor acc_en the accumulator holds. It is always loaded
// before use, so it carries no reset.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_WIDTH = 2*WORD_SIZE_DEF + 5
) (
    input  logic                        clk,
    input  logic                        load,
    input  logic                        acc_en,
    input  logic signed [WORD_SIZE-1:0] bias,
    input  logic signed [WORD_SIZE-1:0] w,
    input  logic signed [WORD_SIZE-1:0] x,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;

    always_comb begin
        prod     = (2*WORD_SIZE)'(w) * (2*WORD_SIZE)'(x);
        prod_ext = ACC_WIDTH'(prod);
        bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc <= bias_ext;
        end else if (acc_en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: Z[j] = sat(sum_i W[j][i]*X[i] + B[j]).
// LANES neurons are evaluated together; the output layer is processed in
// GROUPS groups of IP_LAYER_SIZE accumulate cycles plus one write cycle.
// Ports:
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   start   in  begin an evaluation (accepted only in IDLE)
//   relu_en in  clamp negative results to zero (sampled at accepted start)
//   X       in  input layer, IP_LAYER_SIZE words (held stable until done)
//   W       in  weights W[j][i] (held stable until done)
//   B       in  biases (held stable until done)
//   Z       out registered results
//   busy    out high from the cycle after start acceptance until done
//   done    out one-cycle pulse when all Z are valid
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEF,
    parameter int FRAC_BITS     = FRAC_BITS_DEF,
    parameter int IP_LAYER_SIZE = 10,
    parameter int OP_LAYER_SIZE = 5,
    parameter int LANES         = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 relu_en,
    input  logic [WORD_SIZE-1:0] X [IP_LAYER_SIZE],
    input  logic [WORD_SIZE-1:0] W [OP_LAYER_SIZE][IP_LAYER_SIZE],
    input  logic [WORD_SIZE-1:0] B [OP_LAYER_SIZE],
    output logic [WORD_SIZE-1:0] Z [OP_LAYER_SIZE],
    output logic                 busy,
    output logic                 done
);

    localparam int ACC_WIDTH = 2*WORD_SIZE + $clog2(IP_LAYER_SIZE) + 1;
    localparam int GROUPS    = (OP_LAYER_SIZE + LANES - 1) / LANES;
    localparam int I_W       = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;
    localparam int G_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int N_W       = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;

    state_t                      state;
    logic [I_W-1:0]              i_cnt;
    logic [G_W-1:0]              g_cnt;
    logic                        relu_q;

    logic [G_W-1:0]              load_g;
    logic                        lane_load;
    logic                        lane_acc_en;
    logic                        lane_valid [LANES];
    logic [N_W-1:0]              lane_idx   [LANES];
    logic [WORD_SIZE-1:0]        lane_bias  [LANES];
    logic [WORD_SIZE-1:0]        lane_w     [LANES];
    logic [WORD_SIZE-1:0]        lane_res   [LANES];
    logic signed [ACC_WIDTH-1:0] lane_acc   [LANES];

    // Accumulators are (re)loaded on the accepting start and on every WRITE
    // that is followed by another group; the bias comes from the group about
    // to run, which is 0 from IDLE and g+1 from WRITE.
    assign lane_load   = ((state == IDLE) && start) ||
                         ((state == WRITE) && (g_cnt != G_W'(GROUPS - 1)));
    assign lane_acc_en = (state == ACCUM);

    always_comb begin
        int                      n_cur;
        int                      n_load;
        logic [N_W-1:0]          idx_load;
        logic signed [SAT_W-1:0] r;
        n_cur    = 0;
        n_load   = 0;
        idx_load = '0;
        r        = '0;
        load_g   = (state == IDLE) ? '0 : g_cnt + G_W'(1);
        for (int l = 0; l < LANES; l++) begin
            n_cur         = int'(g_cnt) * LANES + l;
            n_load        = int'(load_g) * LANES + l;
            // Lanes past the last neuron in a partial group see zeros and
            // are never written back, so no index leaves the arrays.
            lane_valid[l] = (n_cur < OP_LAYER_SIZE);
            lane_idx[l]   = lane_valid[l] ? N_W'(n_cur) : '0;
            lane_w[l]     = lane_valid[l] ? W[lane_idx[l]][i_cnt] : '0;
            idx_load      = (n_load < OP_LAYER_SIZE) ? N_W'(n_load) : '0;
            lane_bias[l]  = (n_load < OP_LAYER_SIZE) ? B[idx_load] : '0;
            r             = sat_round(SAT_W'(lane_acc[l]), FRAC_BITS, WORD_SIZE, relu_q);
            lane_res[l]   = r[WORD_SIZE-1:0];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fc_mac_lane #(
            .WORD_SIZE (WORD_SIZE),
            .FRAC_BITS (FRAC_BITS),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .load   (lane_load),
            .acc_en (lane_acc_en),
            .bias   ($signed(lane_bias[l])),
            .w      ($signed(lane_w[l])),
            .x      ($signed(X[i_cnt])),
            .acc    (lane_acc[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            i_cnt  <= '0;
            g_cnt  <= '0;
            relu_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int j = 0; j < OP_LAYER_SIZE; j++) begin
                Z[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        i_cnt  <= '0;
                        g_cnt  <= '0;
                        relu_q <= relu_en;
                        busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (i_cnt == I_W'(IP_LAYER_SIZE - 1)) begin
                        i_cnt <= '0;
                        state <= WRITE;
                    end else begin
                        i_cnt <= i_cnt + I_W'(1);
                    end
                end
                WRITE: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_valid[l]) begin
                            Z[lane_idx[l]] <= lane_res[l];
                        end
                    end
                    if (g_cnt == G_W'(GROUPS - 1)) begin
                        state <= DONE;
                    end else begin
                        g_cnt <= g_cnt + G_W'(1);
                        i_cnt <= '0;
                        state <= ACCUM;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    g_cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: four instances (LANES = 2, 1, 5, 3) share one
// stimulus. A behavioural model predicts busy/done timing and Z from the
// layer equation; literal expectations pin the model on instance 0.
module tb_fc_layer_seq;

    localparam int IP = 10;
    localparam int OP = 5;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic [15:0] X [IP];
    logic [15:0] W [OP][IP];
    logic [15:0] B [OP];
    logic [15:0] z_o [ND][OP];
    logic        busy_o [ND];
    logic        done_o [ND];

    int n_vec  = 0;
    int n_fail = 0;
    int lat [ND];

    always #5 clk = ~clk;

    function automatic int lanes_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int span_of(input int k);
        int g;
        g = (OP + lanes_of(k) - 1) / lanes_of(k);
        return g * (IP + 1) + 1;
    endfunction

    for (genvar k = 0; k < ND; k++) begin : g_dut
        fc_layer_seq #(
            .WORD_SIZE     (16),
            .FRAC_BITS     (8),
            .IP_LAYER_SIZE (IP),
            .OP_LAYER_SIZE (OP),
            .LANES         (lanes_of(k))
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .start   (start),
            .relu_en (relu_en),
            .X       (X),
            .W       (W),
            .B       (B),
            .Z       (z_o[k]),
            .busy    (busy_o[k]),
            .done    (done_o[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Layer equation in plain 64-bit arithmetic.
    function automatic logic [15:0] ref_z(input int j, input bit relu);
        logic signed [63:0] acc;
        acc = 64'($signed(B[j])) * 256;
        for (int i = 0; i < IP; i++) begin
            acc = acc + 64'($signed(W[j][i])) * 64'($signed(X[i]));
        end
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return acc[15:0];
    endfunction

    // Model state
    int          cyc = 0;
    bit          m_run [ND];
    bit          m_done_now [ND];
    int          m_end [ND];
    logic [15:0] exp_z  [ND][OP];
    logic [15:0] pend_z [ND][OP];

    always @(posedge clk or posedge reset) begin
        bit was;
        cyc++;
        if (reset) begin
            for (int k = 0; k < ND; k++) begin
                m_run[k] = 1'b0;
                m_done_now[k] = 1'b0;
                for (int j = 0; j < OP; j++) exp_z[k][j] = 16'h0000;
            end
        end else begin
            for (int k = 0; k < ND; k++) begin
                was = m_run[k];
                m_done_now[k] = 1'b0;
                if (m_run[k] && cyc == m_end[k]) begin
                    for (int j = 0; j < OP; j++) exp_z[k][j] = pend_z[k][j];
                    m_run[k] = 1'b0;
                    m_done_now[k] = 1'b1;
                end
                if (!was && start) begin
                    for (int j = 0; j < OP; j++) pend_z[k][j] = ref_z(j, relu_en);
                    m_end[k] = cyc + span_of(k);
                    m_run[k] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison; Z is only meaningful while no evaluation runs.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_run[k]));
            chk($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_done_now[k]));
            if (!m_run[k]) begin
                for (int j = 0; j < OP; j++) begin
                    chk($sformatf("z[%0d][%0d]", k, j), 32'(z_o[k][j]), 32'(exp_z[k][j]));
                end
            end
        end
    end

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int j = 0; j < OP; j++) begin
            B[j] = bv;
            for (int i = 0; i < IP; i++) W[j][i] = wv;
        end
        for (int i = 0; i < IP; i++) X[i] = xv;
    endtask

    // Called at negedge+1; pulses start and waits (bounded) for every done.
    task automatic run(input bit relu, input bit mid);
        bit all_seen;
        relu_en = relu;
        start = 1'b1;
        for (int k = 0; k < ND; k++) lat[k] = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            #1;
            start = (mid && c == 5);
            all_seen = 1'b1;
            for (int k = 0; k < ND; k++) begin
                if (done_o[k] && lat[k] < 0) lat[k] = c;
                if (lat[k] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill(16'h0000, 16'h0000, 16'h0000);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_z0", 32'(z_o[0][0]), 32'h0);
        chk("reset_busy", 32'(busy_o[0]), 32'h0);

        // Basic: 10 * 1.0 * 1.0 = 10.0; latency per lane count
        fill(16'h0100, 16'h0100, 16'h0000);
        run(1'b0, 1'b0);
        chk("lat_l2", 32'(lat[0]), 32'd35);
        chk("lat_l1", 32'(lat[1]), 32'd57);
        chk("lat_l5", 32'(lat[2]), 32'd13);
        chk("lat_l3", 32'(lat[3]), 32'd24);
        chk("basic_z0", 32'(z_o[0][0]), 32'h0A00);
        chk("basic_l3_z4", 32'(z_o[3][4]), 32'h0A00);

        // Bias, sign and ReLU: -10.0 + 2.0 = -8.0
        fill(16'h0100, 16'hFF00, 16'h0200);
        run(1'b0, 1'b0);
        chk("bias_z2", 32'(z_o[0][2]), 32'hF800);
        run(1'b1, 1'b0);
        chk("relu_z2", 32'(z_o[0][2]), 32'h0000);

        // Saturation both ways
        fill(16'h7FFF, 16'h7FFF, 16'h0000);
        run(1'b0, 1'b0);
        chk("sat_pos_z1", 32'(z_o[0][1]), 32'h7FFF);
        fill(16'h7FFF, 16'h8000, 16'h0000);
        run(1'b0, 1'b0);
        chk("sat_neg_z1", 32'(z_o[0][1]), 32'h8000);

        // Floor rounding: +0.5 lsb -> 0, -0.5 lsb -> -1
        fill(16'h0000, 16'h0000, 16'h0000);
        W[0][0] = 16'h0080;
        X[0] = 16'h0001;
        run(1'b0, 1'b0);
        chk("round_pos_z0", 32'(z_o[0][0]), 32'h0000);
        X[0] = 16'hFFFF;
        run(1'b0, 1'b0);
        chk("round_neg_z0", 32'(z_o[0][0]), 32'hFFFF);

        // Extra start mid-ACCUM is ignored
        fill(16'h0100, 16'h0100, 16'h0000);
        run(1'b0, 1'b1);
        chk("mid_start_lat", 32'(lat[0]), 32'd35);
        chk("mid_start_z3", 32'(z_o[0][3]), 32'h0A00);

        // Reset mid-ACCUM clears outputs at once
        fill(16'h0100, 16'hFF00, 16'h0200);
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_z0", 32'(z_o[0][0]), 32'h0);
        chk("rst_mid_z4", 32'(z_o[0][4]), 32'h0);
        chk("rst_mid_busy", 32'(busy_o[0]), 32'h0);
        chk("rst_mid_done", 32'(done_o[0]), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        run(1'b0, 1'b0);
        chk("after_rst_lat", 32'(lat[0]), 32'd35);
        chk("after_rst_z0", 32'(z_o[0][0]), 32'hF800);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequential, time-multiplexed successor to the combinational fullyConnected layer: computes Z[j] = sat(sum_i W[j][i]*X[i] + B[j]) for OP_LAYER_SIZE neurons.
- Uses LANES parallel MAC units with a start/done handshake.
- Adds fixed-point scaling (FRAC_BITS), saturation, optional ReLU and registered outputs.
- Sits between the conv/pool pipeline output buffer and the classifier argmax stage.

Parameters:
- WORD_SIZE, 16: signed two's-complement word width of X, W, B, Z.
- FRAC_BITS, 8: fractional bits of the Q format; 1.0 = 1<<FRAC_BITS.
- IP_LAYER_SIZE, 10: input neurons.
- OP_LAYER_SIZE, 5: output neurons.
- LANES, 2: parallel MACs, 1..OP_LAYER_SIZE.
- Derived (localparam): ACC_WIDTH = 2*WORD_SIZE + $clog2(IP_LAYER_SIZE) + 1.
- Derived (localparam): GROUPS = ceil(OP_LAYER_SIZE/LANES).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer evaluation; accepted only in IDLE.
- relu_en  in  1  apply ReLU to results; sampled at accepted start.
- X  in  [WORD_SIZE-1:0] x IP_LAYER_SIZE  input layer (unpacked array).
- W  in  [WORD_SIZE-1:0] x OP_LAYER_SIZE x IP_LAYER_SIZE  weights, W[j][i].
- B  in  [WORD_SIZE-1:0] x OP_LAYER_SIZE  biases.
- Z  out  [WORD_SIZE-1:0] x OP_LAYER_SIZE  registered results.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when all Z are valid.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, all Z=0, busy=0, done=0, counters=0, relu latch=0. No partial results survive reset.
- X, W, B must be held stable from start until done; the block does not capture them.
- IDLE: start=1 -> ACCUM. Sets group g=0 and i=0, latches relu_en, and loads each lane acc = sign-extended B[g*LANES+lane] << FRAC_BITS.
- ACCUM: each cycle, every lane does acc += W[n][i]*X[i] (full 2*WORD_SIZE signed product, sign-extended to ACC_WIDTH), with n=g*LANES+lane. i increments; when i==IP_LAYER_SIZE-1 -> WRITE.
- WRITE (1 cycle), per valid lane:
  - r = acc >>> FRAC_BITS (arithmetic shift, floor rounding).
  - Saturate r to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - If the relu latch is set and r<0, r=0.
  - Z[n] <= r.
  - Lanes with n >= OP_LAYER_SIZE (last partial group) are inert: no write, no out-of-range index.
  - If g==GROUPS-1 -> DONE; else g++, i=0, reload accs from the next biases -> ACCUM.
- DONE (1 cycle): done=1, busy=0 -> IDLE. Z holds until overwritten by the next evaluation.
- Latency: start accepted at edge t; done high during the cycle after edge t + GROUPS*(IP_LAYER_SIZE+1) + 1.
- start while busy or in DONE is ignored; it is not queued.
- During a new evaluation, Z entries update group by group. Consumers read Z only on/after done.
- Overflow cannot occur inside the accumulator by construction of ACC_WIDTH; saturation applies only at WRITE.

Decomposition:
- Package fc_pkg:
  - state enum (IDLE, ACCUM, WRITE, DONE).
  - WORD_SIZE/FRAC_BITS defaults.
  - a sat_round function (shift, saturate, ReLU), shared with future conv blocks.
- Sub-module fc_mac_lane: one accumulator with load (bias), accumulate (product) and hold controls; instantiated LANES times via generate.
- Top holds the FSM, counters and Z registers.

Test Plan:
- Basic: IP=10, OP=5, LANES=2, X[i]=W[j][i]=0x0100 (1.0), B=0, relu off -> all Z=0x0A00. done exactly 35 cycles after the start edge (GROUPS=3, 3*11+1, plus the DONE cycle). busy high throughout.
- Bias/sign/ReLU: W=0xFF00 (-1.0), X=0x0100, B[j]=0x0200 -> Z=0xF800 (-8.0) with relu off; Z=0x0000 with relu_en=1 at start.
- Saturation: X=W=0x7FFF -> all Z=0x7FFF. X=0x7FFF, W=0x8000 -> all Z=0x8000.
- Rounding: only W[0][0]=0x0080 nonzero. X[0]=0x0001 -> Z[0]=0x0000. X[0]=0xFFFF -> Z[0]=0xFFFF (floor).
- Handshake/reset: a second start pulse mid-ACCUM is ignored; latency and results unchanged. Asserting reset mid-ACCUM gives Z=0, busy=0, done=0 immediately. A fresh start then completes correctly.
- Parametric sweep, same vectors as Basic: LANES=1 (done after 5*11+2 cycles); LANES=5 (1*11+2); LANES=3 (partial last group, Z[0..4] all correct, no X-propagation).
